l2_noc1_flit_injector: RTL and testbench

//   Upstream feeder for the L2 under verification: takes one abstract coherence message
//   (type, MSHR id, address, source/destination tile, optional data words) and serializes it

---
 rtl/l2_noc1_flit_injector_if.sv | 37 +++
 rtl/l2_noc1_flit_injector.sv | 151 +++++++++++++++
 tb/tb_l2_noc1_flit_injector.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_noc1_flit_injector_if.sv
// Message-in / flit-out channel bundle for the NoC1 flit injector.
// The bench or formal wrapper drives master; the injector sits on slave.
interface l2_noc1_flit_injector_if #(
  parameter int MAX_DATA = 8
);
  logic                   msg_valid;
  logic                   msg_ready;
  logic [7:0]             msg_type;
  logic [7:0]             msg_mshrid;
  logic [47:0]            msg_addr;
  logic [13:0]            msg_dst_chipid;
  logic [7:0]             msg_dst_x;
  logic [7:0]             msg_dst_y;
  logic [7:0]             msg_src_x;
  logic [7:0]             msg_src_y;
  logic [3:0]             msg_ndata;
  logic [64*MAX_DATA-1:0] msg_data;
  logic                   noc_valid;
  logic                   noc_ready;
  logic [63:0]            noc_data;

  modport master (
    output msg_valid, msg_type, msg_mshrid, msg_addr,
    output msg_dst_chipid, msg_dst_x, msg_dst_y,
    output msg_src_x, msg_src_y, msg_ndata, msg_data,
    output noc_ready,
    input  msg_ready, noc_valid, noc_data
  );

  modport slave (
    input  msg_valid, msg_type, msg_mshrid, msg_addr,
    input  msg_dst_chipid, msg_dst_x, msg_dst_y,
    input  msg_src_x, msg_src_y, msg_ndata, msg_data,
    input  noc_ready,
    output msg_ready, noc_valid, noc_data
  );
endinterface

// File: rtl/l2_noc1_flit_injector.sv
// Serializes one abstract coherence message into HDR1/HDR2/HDR3/data
// 64-bit NoC flits on a valid/ready channel; all outputs registered.
module l2_noc1_flit_injector #(
  parameter int MAX_DATA    = 8,
  parameter int STALL_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  l2_noc1_flit_injector_if.slave      bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_len_err,
  output logic                        o_stall_err
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LP_LIM  = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] LP_LIM1 = CW'(STALL_LIMIT - 1);
  localparam logic [3:0]    LP_MAXD = 4'(MAX_DATA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_DATA
  } state_t;

  state_t                 r_state;
  logic [47:0]            r_addr;
  logic [13:0]            r_chip;
  logic [7:0]             r_sx;
  logic [7:0]             r_sy;
  logic [3:0]             r_ndata;
  logic [3:0]             r_idx;
  logic [64*MAX_DATA-1:0] r_data;
  logic                   r_msg_ready;
  logic                   r_noc_valid;
  logic [63:0]            r_noc_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_len_err;
  logic                   r_stall_err;
  logic [CW-1:0]          r_stall_cnt;

  logic                   w_hs;
  logic                   w_last;
  logic                   w_over;
  logic [3:0]             w_ndata;
  logic [7:0]             w_plen;
  logic [63:0]            w_hdr1;
  logic [3:0]             w_idx_nxt;

  assign w_hs      = r_noc_valid && bus.noc_ready;
  assign w_over    = bus.msg_ndata > LP_MAXD;
  assign w_ndata   = w_over ? LP_MAXD : bus.msg_ndata;
  assign w_plen    = 8'd2 + {4'd0, w_ndata};
  assign w_idx_nxt = r_idx + 4'd1;

  // HDR1 is built straight from the inputs so it is valid the cycle after accept
  assign w_hdr1 = {bus.msg_dst_chipid, bus.msg_dst_x, bus.msg_dst_y,
                   4'd0, w_plen, bus.msg_type, bus.msg_mshrid, 6'd0};

  assign w_last = ((r_state == S_HDR3) && (r_ndata == 4'd0)) ||
                  ((r_state == S_DATA) && (w_idx_nxt == r_ndata));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_chip      <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_ndata     <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_msg_ready <= 1'b1;
      r_noc_valid <= 1'b0;
      r_noc_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_len_err   <= 1'b0;
      r_stall_err <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.msg_valid) begin
          r_addr      <= bus.msg_addr;
          r_chip      <= bus.msg_dst_chipid;
          r_sx        <= bus.msg_src_x;
          r_sy        <= bus.msg_src_y;
          r_ndata     <= w_ndata;
          r_data      <= bus.msg_data;
          r_idx       <= '0;
          r_state     <= S_HDR1;
          r_msg_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_noc_valid <= 1'b1;
          r_noc_data  <= w_hdr1;
          if (w_over) r_len_err <= 1'b1;
        end
      end else if (w_hs) begin
        if (w_last) begin
          r_state     <= S_IDLE;
          r_msg_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_noc_valid <= 1'b0;
          r_noc_data  <= '0;
          r_done      <= 1'b1;
        end else begin
          unique case (r_state)
            S_HDR1: begin
              r_state    <= S_HDR2;
              r_noc_data <= {r_addr, 16'd0};
            end
            S_HDR2: begin
              r_state    <= S_HDR3;
              r_noc_data <= {r_chip, r_sx, r_sy, 34'd0};
            end
            S_HDR3: begin
              r_state    <= S_DATA;
              r_idx      <= '0;
              r_noc_data <= r_data[63:0];
            end
            S_DATA: begin
              r_idx      <= w_idx_nxt;
              r_noc_data <= r_data[64*w_idx_nxt +: 64];
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end

      // consecutive stalled-valid cycles; the transfer itself never aborts
      if ((r_state == S_IDLE) || w_hs) begin
        r_stall_cnt <= '0;
      end else if (!bus.noc_ready) begin
        if (r_stall_cnt != LP_LIM) r_stall_cnt <= r_stall_cnt + 1'b1;
        if (r_stall_cnt >= LP_LIM1) r_stall_err <= 1'b1;
      end
    end
  end

  assign bus.msg_ready = r_msg_ready;
  assign bus.noc_valid = r_noc_valid;
  assign bus.noc_data  = r_noc_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_len_err     = r_len_err;
  assign o_stall_err   = r_stall_err;
endmodule

// File: tb/tb_l2_noc1_flit_injector.sv
// Randomized and directed bench for l2_noc1_flit_injector with a
// message-level reference model building expected flit streams.
module tb_l2_noc1_flit_injector;
  localparam int MD = 8;
  localparam int SL = 4;

  typedef struct packed {
    logic [7:0]       typ;
    logic [7:0]       mshr;
    logic [47:0]      addr;
    logic [13:0]      chip;
    logic [7:0]       dx;
    logic [7:0]       dy;
    logic [7:0]       sx;
    logic [7:0]       sy;
    logic [3:0]       nd;
    logic [64*MD-1:0] d;
  } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, len_err, stall_err;
  always #5 clk = ~clk;

  l2_noc1_flit_injector_if #(.MAX_DATA(MD)) bus();

  l2_noc1_flit_injector #(
    .MAX_DATA(MD),
    .STALL_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .o_busy(busy),
    .o_done(done),
    .o_len_err(len_err),
    .o_stall_err(stall_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] got_q[$];
  int          got_c[$];
  int          done_c[$];
  logic [63:0] exp_q[$];
  int          acc_last = -1000;
  int          stab_err = 0;
  int          zero_err = 0;
  logic        pv = 1'b0;
  logic [63:0] pd = '0;
  logic        busy_log[0:8191];

  // channel monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.noc_valid && bus.noc_ready) begin
        got_q.push_back(bus.noc_data);
        got_c.push_back(cyc);
      end
      if (done) done_c.push_back(cyc);
      if (bus.msg_valid && bus.msg_ready) acc_last = cyc;
      if (pv && !(bus.noc_valid && bus.noc_data == pd)) stab_err++;
    end
    if (!bus.noc_valid && bus.noc_data != 64'd0) zero_err++;
    pv = bus.noc_valid && !bus.noc_ready && !rst;
    pd = bus.noc_data;
    if (cyc >= 0 && cyc < 8192) busy_log[cyc] = busy;
  end

  int rmode = 0;
  int lo_off = 0;
  int lo_len = 0;
  initial begin
    bus.noc_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.noc_ready = 1'b1;
        1: bus.noc_ready = ($urandom_range(0, 3) != 0);
        default: bus.noc_ready = !((cyc >= acc_last + lo_off) &&
                                   (cyc < acc_last + lo_off + lo_len));
      endcase
    end
  end

  function automatic void model(input msg_t m);
    int n;
    logic [63:0] plen;
    n = (m.nd > MD) ? MD : int'(m.nd);
    plen = 64'(2 + n);
    exp_q.push_back((64'(m.chip) << 50) | (64'(m.dx) << 42) |
                    (64'(m.dy) << 34) | (plen << 22) |
                    (64'(m.typ) << 14) | (64'(m.mshr) << 6));
    exp_q.push_back(64'(m.addr) << 16);
    exp_q.push_back((64'(m.chip) << 50) | (64'(m.sx) << 42) |
                    (64'(m.sy) << 34));
    for (int i = 0; i < n; i++) exp_q.push_back(m.d[64*i +: 64]);
  endfunction

  function automatic msg_t rand_msg(input int nd_max);
    msg_t m;
    m.typ  = 8'($urandom);
    m.mshr = 8'($urandom);
    m.addr = {16'($urandom), 32'($urandom)};
    m.chip = 14'($urandom);
    m.dx   = 8'($urandom);
    m.dy   = 8'($urandom);
    m.sx   = 8'($urandom);
    m.sy   = 8'($urandom);
    m.nd   = 4'($urandom_range(0, nd_max));
    for (int i = 0; i < MD; i++)
      m.d[64*i +: 64] = {32'($urandom), 32'($urandom)};
    return m;
  endfunction

  task automatic drive(input msg_t m);
    bus.msg_type       = m.typ;
    bus.msg_mshrid     = m.mshr;
    bus.msg_addr       = m.addr;
    bus.msg_dst_chipid = m.chip;
    bus.msg_dst_x      = m.dx;
    bus.msg_dst_y      = m.dy;
    bus.msg_src_x      = m.sx;
    bus.msg_src_y      = m.sy;
    bus.msg_ndata      = m.nd;
    bus.msg_data       = m.d;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_c.delete();
    done_c.delete();
    exp_q.delete();
  endtask

  task automatic send(input msg_t m, output int acc);
    bit ok = 0;
    acc = -1;
    @(posedge clk);
    #1;
    drive(m);
    bus.msg_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.msg_ready) begin ok = 1; acc = cyc; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: msg_ready=%0b required 1", bus.msg_ready);
    end
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    drive(rand_msg(15));
  endtask

  task automatic wait_done(input int n0);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (done_c.size() > n0) ok = 1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: done_count=%0d required >%0d", done_c.size(), n0);
    end
  endtask

  task automatic test_reset();
    bus.msg_valid = 1'b0;
    drive(rand_msg(8));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.msg_ready, bus.noc_valid, busy, done, len_err, stall_err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: rdy,vld,busy,done,len,stall=%b required 100000",
               {bus.msg_ready, bus.noc_valid, busy, done, len_err, stall_err});
    end
    n_chk++;
    if (bus.noc_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: noc_data=%h required 0", bus.noc_data);
    end
  endtask

  task automatic test_hdr_only();
    msg_t m;
    int acc;
    clear_q();
    m = rand_msg(0);
    m.typ = 8'h0E;
    m.mshr = 8'd3;
    m.addr = 48'h0000_1234_5640;
    m.nd = 4'd0;
    model(m);
    send(m, acc);
    wait_done(0);
    n_chk++;
    if (got_q.size() != 3 || got_q != exp_q) begin
      n_fail++;
      $display("FAIL hdr_only_stream: %0d flits required 3 matching model", got_q.size());
    end
    if (got_q.size() == 3) begin
      n_chk++;
      if (got_q[0][29:22] !== 8'd2) begin
        n_fail++;
        $display("FAIL hdr_only_plen: %0d required 2", got_q[0][29:22]);
      end
      n_chk++;
      if (got_q[1] !== 64'h0000_1234_5640_0000) begin
        n_fail++;
        $display("FAIL hdr_only_hdr2: %h required 0000123456400000", got_q[1]);
      end
      n_chk++;
      if (done_c[0] != got_c[2] + 1 || done_c[0] != acc + 4) begin
        n_fail++;
        $display("FAIL hdr_only_done: done@%0d hdr3@%0d required %0d", done_c[0], got_c[2], acc + 4);
      end
    end
  endtask

  function automatic msg_t two_word_msg();
    msg_t m;
    m = rand_msg(0);
    m.nd = 4'd2;
    m.d[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;
    m.d[127:64] = 64'h5555_5555_5555_5555;
    return m;
  endfunction

  task automatic test_data2();
    msg_t m;
    int acc;
    logic [6:0] bl;
    clear_q();
    m = two_word_msg();
    model(m);
    send(m, acc);
    wait_done(0);
    @(negedge clk);
    n_chk++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL data2_stream: %0d flits required 5 matching model", got_q.size());
    end
    n_chk++;
    if (got_q.size() == 5 && (got_q[0][29:22] !== 8'd4 || got_q[3] !== 64'hAAAA_AAAA_AAAA_AAAA)) begin
      n_fail++;
      $display("FAIL data2_fields: plen=%0d d0=%h required 4 / AAAA..", got_q[0][29:22], got_q[3]);
    end
    n_chk++;
    if (done_c.size() != 1 || done_c[0] != acc + 6) begin
      n_fail++;
      $display("FAIL data2_done: done count %0d at %0d required 1 at %0d",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, acc + 6);
    end
    for (int i = 0; i < 7; i++) bl[i] = busy_log[acc + i];
    n_chk++;
    if (bl !== 7'b0111110) begin
      n_fail++;
      $display("FAIL data2_busy: busy acc+6..acc=%b required 0111110", bl);
    end
  endtask

  task automatic test_stall_hdr2();
    msg_t m;
    int acc;
    int ec[5];
    clear_q();
    stab_err = 0;
    m = two_word_msg();
    model(m);
    acc_last = -1000;
    lo_off = 2;
    lo_len = 3;
    rmode = 2;
    send(m, acc);
    wait_done(0);
    rmode = 0;
    ec = '{acc + 1, acc + 5, acc + 6, acc + 7, acc + 8};
    n_chk++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL stall3_stream: %0d flits required 5 matching model", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_c.size(); i++) begin
      n_chk++;
      if (got_c[i] != ec[i]) begin
        n_fail++;
        $display("FAIL stall3_flit%0d_cycle: %0d required %0d", i, got_c[i], ec[i]);
      end
    end
    n_chk++;
    if (done_c[0] != acc + 9 || stab_err != 0) begin
      n_fail++;
      $display("FAIL stall3_done: done@%0d stab_err=%0d required %0d / 0", done_c[0], stab_err, acc + 9);
    end
    n_chk++;
    if (stall_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall3_no_err: stall_err=%b required 0", stall_err);
    end
  endtask

  task automatic test_back_to_back();
    msg_t a, b;
    int acc_b = -1;
    bit ok = 0;
    clear_q();
    a = rand_msg(0);
    a.nd = 4'd1;
    b = rand_msg(0);
    b.nd = 4'd3;
    model(a);
    model(b);
    @(posedge clk);
    #1;
    drive(a);
    bus.msg_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.msg_ready) ok = 1;
    end
    @(posedge clk);
    #1;
    drive(b);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.msg_ready) begin ok = 1; acc_b = cyc; end
    end
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    wait_done(1);
    n_chk++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL b2b_stream: %0d flits required %0d matching model", got_q.size(), exp_q.size());
    end
    if (got_c.size() == 10 && done_c.size() == 2) begin
      n_chk++;
      if (done_c[0] != acc_b || got_c[3] != acc_b - 1 || got_c[4] != acc_b + 1) begin
        n_fail++;
        $display("FAIL b2b_timing: doneA@%0d lastA@%0d hdr1B@%0d required %0d/%0d/%0d",
                 done_c[0], got_c[3], got_c[4], acc_b, acc_b - 1, acc_b + 1);
      end
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL b2b_counts: flits=%0d dones=%0d required 10/2", got_c.size(), done_c.size());
    end
  endtask

  task automatic test_len_stall();
    msg_t m;
    int acc;
    clear_q();
    @(negedge clk);
    n_chk++;
    if (len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL len_before: len_err=%b required 0", len_err);
    end
    m = rand_msg(0);
    m.nd = 4'd12;
    model(m);
    acc_last = -1000;
    lo_off = 6;
    lo_len = 4;
    rmode = 2;
    send(m, acc);
    while (cyc < acc + 9) @(negedge clk);
    n_chk++;
    if (stall_err !== 1'b0 || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stall4_pre: stall_err=%b len_err=%b required 0/1", stall_err, len_err);
    end
    @(negedge clk);
    n_chk++;
    if (stall_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stall4_set: stall_err=%b required 1", stall_err);
    end
    wait_done(0);
    rmode = 0;
    n_chk++;
    if (got_q.size() != 11 || got_q != exp_q) begin
      n_fail++;
      $display("FAIL clamp_stream: %0d flits required 11 matching model", got_q.size());
    end
    n_chk++;
    if (got_q.size() > 0 && got_q[0][29:22] !== 8'd10) begin
      n_fail++;
      $display("FAIL clamp_plen: %0d required 10", got_q[0][29:22]);
    end
    n_chk++;
    if (done_c[0] != acc + 16) begin
      n_fail++;
      $display("FAIL clamp_done: done@%0d required %0d", done_c[0], acc + 16);
    end
  endtask

  task automatic test_random();
    msg_t m;
    int acc;
    stab_err = 0;
    zero_err = 0;
    rmode = 1;
    for (int t = 0; t < 25; t++) begin
      clear_q();
      m = rand_msg(10);
      model(m);
      send(m, acc);
      wait_done(0);
      n_chk++;
      if (got_q != exp_q || done_c[0] != got_c[got_c.size() - 1] + 1) begin
        n_fail++;
        $display("FAIL rand%0d_stream: %0d flits done@%0d required %0d flits done after last",
                 t, got_q.size(), done_c[0], exp_q.size());
      end
    end
    rmode = 0;
    n_chk++;
    if (stab_err != 0 || zero_err != 0) begin
      n_fail++;
      $display("FAIL rand_protocol: stab_err=%0d zero_err=%0d required 0/0", stab_err, zero_err);
    end
  endtask

  task automatic test_mid_reset();
    msg_t m;
    int acc;
    clear_q();
    m = rand_msg(0);
    m.nd = 4'd4;
    model(m);
    send(m, acc);
    while (cyc < acc + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.noc_valid, busy, bus.msg_ready, len_err, stall_err} !== 5'b00100 ||
        bus.noc_data !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: vld,busy,rdy,len,stall=%b data=%h required 00100/0",
               {bus.noc_valid, busy, bus.msg_ready, len_err, stall_err}, bus.noc_data);
    end
    n_chk++;
    if (got_q.size() != 4 || got_q[0] !== exp_q[0] || got_q[3] !== exp_q[3]) begin
      n_fail++;
      $display("FAIL rst_mid_partial: %0d flits before reset required 4 matching", got_q.size());
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if (done_c.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: %0d done pulses required 0", done_c.size());
    end
    clear_q();
    m = rand_msg(8);
    model(m);
    send(m, acc);
    wait_done(0);
    n_chk++;
    if (got_q != exp_q || got_c[0] != acc + 1) begin
      n_fail++;
      $display("FAIL rst_mid_resend: %0d flits hdr1@%0d required %0d flits at %0d",
               got_q.size(), got_c.size() > 0 ? got_c[0] : -1, exp_q.size(), acc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_hdr_only();
    test_data2();
    test_stall_hdr2();
    test_back_to_back();
    test_len_stall();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
